store_buffer: RTL

Four-entry store buffer between the execute stage and the 16-bit data memory. Queues pipeline stores and drains them into the memory's single write port, one per cycle, whenever the pipeline is not using that port for a load. Forwards buffered store data to younger loads to the same word, so loads never see stale memory. Drives the memory's address, write-data and write-enable inputs directly.

---
 rtl/store_buffer.sv | 89 ++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Four-entry store buffer: queues pipeline stores, drains them into the data memory's
// single write port when loads are not using it, and forwards queued data to younger loads.
module store_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         St_valid,
  input  logic [N-1:0] St_addr,
  input  logic [N-1:0] St_data,
  output logic         St_ready,
  input  logic         Ld_valid,
  input  logic [N-1:0] Ld_addr,
  output logic         Ld_hit,
  output logic [N-1:0] Ld_data,
  output logic [N-1:0] Mem_ad,
  output logic [N-1:0] Mem_wdata,
  output logic         Mem_write,
  output logic         Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [N-1:0]  data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic unused_st_addr_hi;

  // Only the low AW address bits reach the memory, so the rest of the store address is dropped.
  assign unused_st_addr_hi = ^St_addr[N-1:AW];

  assign St_ready  = (count < CW'(DEPTH));
  assign Empty     = (count == '0);
  assign push      = St_valid && St_ready;
  assign pop       = (count != '0) && !Ld_valid;
  assign Mem_write = pop;
  assign Mem_ad    = Ld_valid ? Ld_addr : N'(addr_q[head]);
  assign Mem_wdata = data_q[head];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= St_addr[AW-1:0];
        data_q[tail] <= St_data;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    Ld_hit  = 1'b0;
    Ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == Ld_addr[AW-1:0])) begin
        Ld_hit  = 1'b1;
        Ld_data = data_q[idx];
      end
    end
  end

endmodule
